// File: rtl/param_fifo_pkg.sv
// Shared constants and sizing helpers for the param_fifo block.
// Optional error flags are enabled with the PARAM_FIFO_ERR_EN macro in param_fifo.
package param_fifo_pkg;

    localparam int C_DEF_DATA_WIDTH   = 8;
    localparam int C_DEF_FIFO_DEPTH   = 4;
    localparam int C_DEF_AEMPTY_LEVEL = 1;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width; a single-entry FIFO still needs one address bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/param_fifo_ram.sv
// Storage array for param_fifo: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module fifo_ram #(
    parameter int C_DATA_WIDTH = 8,
    parameter int C_FIFO_DEPTH = 4,
    parameter int C_PTR_WIDTH  = 2
) (
    input  logic                    clk,
    input  logic                    wr_en_i,
    input  logic [C_PTR_WIDTH-1:0]  wr_addr_i,
    input  logic [C_DATA_WIDTH-1:0] wr_data_i,
    input  logic [C_PTR_WIDTH-1:0]  rd_addr_i,
    output logic [C_DATA_WIDTH-1:0] rd_data_o
);

    logic [C_DATA_WIDTH-1:0] mem_q [0:C_FIFO_DEPTH-1];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/param_fifo.sv
// First-word-fall-through FIFO with registered occupancy flags and arbitrary depth.
// Define PARAM_FIFO_ERR_EN to add sticky ovf_err/udf_err outputs.
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int C_DATA_WIDTH   = C_DEF_DATA_WIDTH,
    parameter int C_FIFO_DEPTH   = C_DEF_FIFO_DEPTH,
    parameter int C_AFULL_LEVEL  = C_FIFO_DEPTH - 1,
    parameter int C_AEMPTY_LEVEL = C_DEF_AEMPTY_LEVEL
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  write_valid,
    output logic                                  write_ready,
    input  logic [C_DATA_WIDTH-1:0]               write_data,
    output logic                                  read_valid,
    input  logic                                  read_ready,
    output logic [C_DATA_WIDTH-1:0]               read_data,
    output logic                                  full,
    output logic                                  empty,
    output logic                                  almost_full,
    output logic                                  almost_empty,
    output logic [level_width(C_FIFO_DEPTH)-1:0]  level
`ifdef PARAM_FIFO_ERR_EN
    ,
    output logic                                  ovf_err,
    output logic                                  udf_err
`endif
);

    localparam int LW = level_width(C_FIFO_DEPTH);
    localparam int PW = ptr_width(C_FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(C_FIFO_DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(C_FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_AFULL = LW'(C_AFULL_LEVEL);
    localparam logic [LW-1:0] LVL_AEMPT = LW'(C_AEMPTY_LEVEL);

    logic          wr_en_s, rd_en_s;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          afull_q, afull_d, aempty_q, aempty_d;

    // Commit decode, pointer wrap and next occupancy; flags derive from the next level.
    always_comb begin
        wr_en_s = write_valid && !full_q;
        rd_en_s = read_ready && !empty_q;

        if (!wr_en_s) begin
            wr_ptr_d = wr_ptr_q;
        end else if (wr_ptr_q == LAST_PTR) begin
            wr_ptr_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (!rd_en_s) begin
            rd_ptr_d = rd_ptr_q;
        end else if (rd_ptr_q == LAST_PTR) begin
            rd_ptr_d = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (wr_en_s && !rd_en_s) begin
            level_d = level_q + LVL_ONE;
        end else if (rd_en_s && !wr_en_s) begin
            level_d = level_q - LVL_ONE;
        end else begin
            level_d = level_q;
        end

        full_d   = (level_d == LVL_FULL);
        empty_d  = (level_d == '0);
        afull_d  = (level_d >= LVL_AFULL);
        aempty_d = (level_d <= LVL_AEMPT);
    end

    // Control state; reset overrides any transfer offered in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

`ifdef PARAM_FIFO_ERR_EN
    logic ovf_q, udf_q;

    // Sticky protocol-violation flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q || (write_valid && full_q);
            udf_q <= udf_q || (read_ready && empty_q);
        end
    end

    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`endif

    fifo_ram #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .C_FIFO_DEPTH (C_FIFO_DEPTH),
        .C_PTR_WIDTH  (PW)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en_s),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (write_data),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (read_data)
    );

    assign write_ready  = !full_q;
    assign read_valid   = !empty_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign level        = level_q;

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo (depth 4, width 8): directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a queue-based model.
module tb_param_fifo;

    localparam int DW     = 8;
    localparam int DEPTH  = 4;
    localparam int AFULL  = DEPTH - 1;
    localparam int AEMPTY = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          write_valid = 1'b0;
    logic          write_ready;
    logic [DW-1:0] write_data = '0;
    logic          read_valid;
    logic          read_ready = 1'b0;
    logic [DW-1:0] read_data;
    logic          full, empty, almost_full, almost_empty;
    logic [2:0]    level;
`ifdef PARAM_FIFO_ERR_EN
    logic          ovf_err, udf_err;
`endif

    param_fifo #(
        .C_DATA_WIDTH (DW),
        .C_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write_valid  (write_valid),
        .write_ready  (write_ready),
        .write_data   (write_data),
        .read_valid   (read_valid),
        .read_ready   (read_ready),
        .read_data    (read_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level)
`ifdef PARAM_FIFO_ERR_EN
        ,
        .ovf_err      (ovf_err),
        .udf_err      (udf_err)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of stored words plus sticky error bits.
    logic [DW-1:0] mq[$];
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;
    bit            checking = 1'b0;
    int            vectors = 0;
    int            miscompares = 0;

    function automatic void chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_update(input logic rst, input logic wv,
                                         input logic [DW-1:0] wd, input logic rr);
        bit wc, rc;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            wc = wv && (mq.size() < DEPTH);
            rc = rr && (mq.size() > 0);
            if (wv && mq.size() == DEPTH) m_ovf = 1'b1;
            if (rr && mq.size() == 0) m_udf = 1'b1;
            if (rc) void'(mq.pop_front());
            if (wc) mq.push_back(wd);
        end
    endfunction

    // One clock of stimulus; returns 1 time unit after the rising edge.
    task automatic step(input logic rst, input logic wv, input logic [DW-1:0] wd, input logic rr);
        reset       = rst;
        write_valid = wv;
        write_data  = wd;
        read_ready  = rr;
        @(posedge clk);
        model_update(rst, wv, wd, rr);
        #1;
        checking = 1'b1;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (checking) begin
            chk("level", int'(level), mq.size());
            chk("full", int'(full), int'(mq.size() == DEPTH));
            chk("empty", int'(empty), int'(mq.size() == 0));
            chk("write_ready", int'(write_ready), int'(mq.size() != DEPTH));
            chk("read_valid", int'(read_valid), int'(mq.size() != 0));
            chk("almost_full", int'(almost_full), int'(mq.size() >= AFULL));
            chk("almost_empty", int'(almost_empty), int'(mq.size() <= AEMPTY));
            if (mq.size() > 0) chk("read_data", int'(read_data), int'(mq[0]));
`ifdef PARAM_FIFO_ERR_EN
            chk("ovf_err", int'(ovf_err), int'(m_ovf));
            chk("udf_err", int'(udf_err), int'(m_udf));
`endif
        end
    end

    logic [DW-1:0] abcd [4];

    initial begin
        abcd[0] = 8'h61; abcd[1] = 8'h62; abcd[2] = 8'h63; abcd[3] = 8'h64;

        // Reset state.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b1);
        chk("rst_level", int'(level), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_read_valid", int'(read_valid), 0);
        chk("rst_write_ready", int'(write_ready), 1);
        chk("rst_aempty", int'(almost_empty), 1);
        chk("rst_afull", int'(almost_full), 0);

        // Write into an empty FIFO is not passed through in the same cycle.
        step(1'b0, 1'b1, 8'h61, 1'b1);
        chk("pt_read_valid", int'(read_valid), 1);
        chk("pt_read_data", int'(read_data), 32'h61);
        chk("pt_level", int'(level), 1);
        chk("pt_model_level", mq.size(), 1);

        // Fill, refuse a fifth word, drain in order.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, abcd[i], 1'b0);
        chk("fill_full", int'(full), 1);
        chk("fill_afull", int'(almost_full), 1);
        chk("fill_write_ready", int'(write_ready), 0);
        step(1'b0, 1'b1, 8'h65, 1'b0);
        chk("e_level", int'(level), 4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", int'(read_data), int'(abcd[i]));
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        chk("drain_empty", int'(empty), 1);

        // Full with simultaneous read and write: only the read commits.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, abcd[i], 1'b0);
        step(1'b0, 1'b1, 8'h78, 1'b1);
        chk("fullrw_level", int'(level), 3);
        chk("fullrw_model_level", mq.size(), 3);
        for (int i = 1; i < 4; i++) begin
            chk("fullrw_data", int'(read_data), int'(abcd[i]));
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        chk("fullrw_empty", int'(empty), 1);

        // Level 2 with six simultaneous read+write cycles; pointers wrap.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h31, 1'b0);
        step(1'b0, 1'b1, 8'h32, 1'b0);
        for (int k = 0; k < 6; k++) begin
            chk("wrap_data", int'(read_data), 32'h31 + k);
            step(1'b0, 1'b1, 8'(8'h33 + k), 1'b1);
            chk("wrap_level", int'(level), 2);
        end
        chk("wrap_tail0", int'(read_data), 32'h37);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("wrap_tail1", int'(read_data), 32'h38);

        // Mid-stream reset at level 3.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, abcd[i], 1'b0);
        step(1'b1, 1'b1, 8'h71, 1'b1);
        chk("mrst_level", int'(level), 0);
        chk("mrst_empty", int'(empty), 1);
        chk("mrst_read_valid", int'(read_valid), 0);
        step(1'b0, 1'b1, 8'h7a, 1'b0);
        chk("mrst_z", int'(read_data), 32'h7a);

`ifdef PARAM_FIFO_ERR_EN
        // Sticky error flags.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("udf_set", int'(udf_err), 1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, abcd[i], 1'b0);
        chk("ovf_clear_before", int'(ovf_err), 0);
        step(1'b0, 1'b1, 8'h65, 1'b0);
        chk("ovf_set", int'(ovf_err), 1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("ovf_sticky", int'(ovf_err), 1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("ovf_reset", int'(ovf_err), 0);
        chk("udf_reset", int'(udf_err), 0);
`endif

        // Randomized traffic with occasional resets, biased toward both full and empty.
        for (int n = 0; n < 3000; n++) begin
            int bias;
            bias = (n / 300) % 3;
            step(($urandom_range(63) == 0),
                 ($urandom_range(9) < (bias == 0 ? 8 : (bias == 1 ? 2 : 5))),
                 8'($urandom),
                 ($urandom_range(9) < (bias == 0 ? 2 : (bias == 1 ? 8 : 5))));
        end

        @(negedge clk);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
